// File: rtl/vedic_pkg.sv
// vedic_pkg: shared state encoding and partial-product shift table for the sequential Vedic multiplier
package vedic_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int STEPS = 4;
  function automatic int shift_of(input logic [1:0] step, input int half);
    return step == 2'd0 ? 0 : step == 2'd3 ? 2 * half : half;
  endfunction
endpackage

// File: rtl/vedic_mult_half.sv
// vedic_mult_half: combinational HALF x HALF Urdhva-Tiryagbhyam (vertical and crosswise) multiplier
module vedic_mult_half #(
  parameter int HALF = 4
) (
  input  logic [HALF-1:0]   x,
  input  logic [HALF-1:0]   y,
  output logic [2*HALF-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < HALF; i++)
      for (int j = 0; j < HALF; j++)
        p = p + ((2*HALF)'(x[i] & y[j]) << (i + j));
  end
endmodule

// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq: iterative WIDTH x WIDTH multiplier, one HALF x HALF partial product per cycle
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int HALF = WIDTH / 2;
  state_t state, state_n;
  logic [1:0] step;
  logic [WIDTH-1:0] ra, rb;
  logic [2*WIDTH-1:0] acc;
  logic [HALF-1:0] x, y;
  logic [2*HALF-1:0] pp;
  // step[0] selects the high half of a, step[1] the high half of b
  assign x = step[0] ? ra[WIDTH-1:HALF] : ra[HALF-1:0];
  assign y = step[1] ? rb[WIDTH-1:HALF] : rb[HALF-1:0];
  vedic_mult_half #(.HALF(HALF)) u_half (.x(x), .y(y), .p(pp));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign product   = out_valid ? acc : '0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE)
            : state == CALC ? (step == 2'(STEPS - 1) ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        ra   <= a;
        rb   <= b;
        acc  <= '0;
        step <= '0;
      end
      if (state == CALC) begin
        acc  <= acc + ((2*WIDTH)'(pp) << shift_of(step, HALF));
        step <= step + 2'd1;
      end
    end
  end
endmodule
